// File: rtl/mult_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the multiply-accumulate datapath.
//   - state_e         : accumulate-stage FSM states (IDLE, ACC, HOLD)
//   - prodWidth()     : product width from the two multiplier operand widths
//   - accWidth()      : accumulator width (product plus guard bits)
//   - signedMax()     : largest two's complement value of an A-bit accumulator
//   - signedMin()     : most negative two's complement value (bit pattern)
//   - unsignedMax()   : all-ones value of an A-bit accumulator
// The limit helpers return LIMIT_W-bit values; users keep the low A bits.
// ---------------------------------------------------------------------------
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam int COUNT_W = 16;
  localparam logic [COUNT_W-1:0] COUNT_MAX = 16'hFFFF;

  // Widest accumulator the limit helpers can describe.
  localparam int LIMIT_W = 64;

  function automatic int prodWidth(input int wl1, input int wl2);
    return wl1 + wl2;
  endfunction

  function automatic int accWidth(input int wl1, input int wl2, input int guard);
    return wl1 + wl2 + guard;
  endfunction

  // 2^(a-1)-1 : positive clamp value in signed mode.
  function automatic logic [LIMIT_W-1:0] signedMax(input int a);
    return (LIMIT_W'(1) << (a - 1)) - LIMIT_W'(1);
  endfunction

  // -2^(a-1) : only the sign bit set once truncated to a bits.
  function automatic logic [LIMIT_W-1:0] signedMin(input int a);
    return LIMIT_W'(1) << (a - 1);
  endfunction

  // 2^a-1 : clamp value in unsigned mode.
  function automatic logic [LIMIT_W-1:0] unsignedMax(input int a);
    if (a >= LIMIT_W) begin
      return '1;
    end
    return (LIMIT_W'(1) << a) - LIMIT_W'(1);
  endfunction

endpackage

// File: rtl/mult_acc_satadd.sv
// ---------------------------------------------------------------------------
// mult_acc_satadd
// Combinational saturating adder used by the accumulate stage.
// Ports:
//   acc    in  A  current accumulator value
//   addend in  A  extended product to add
//   mode   in  1  1 = two's complement arithmetic, 0 = unsigned
//   sum    out A  saturated result
//   ovf    out 1  the raw sum did not fit and was clamped
// ---------------------------------------------------------------------------
module mult_acc_satadd
  import mult_pkg::*;
#(
  parameter int A = 24
) (
  input  logic [A-1:0] acc,
  input  logic [A-1:0] addend,
  input  logic         mode,
  output logic [A-1:0] sum,
  output logic         ovf
);

  localparam logic [LIMIT_W-1:0] S_MAX_FULL = signedMax(A);
  localparam logic [LIMIT_W-1:0] S_MIN_FULL = signedMin(A);
  localparam logic [LIMIT_W-1:0] U_MAX_FULL = unsignedMax(A);
  localparam logic [A-1:0]       S_MAX      = S_MAX_FULL[A-1:0];
  localparam logic [A-1:0]       S_MIN      = S_MIN_FULL[A-1:0];
  localparam logic [A-1:0]       U_MAX      = U_MAX_FULL[A-1:0];

  logic [A:0] w_raw;
  logic       w_carry;
  logic       w_signedOvf;

  // One extra bit captures the unsigned carry-out.
  assign w_raw   = {1'b0, acc} + {1'b0, addend};
  assign w_carry = w_raw[A];

  // Signed overflow: operands agree in sign but the result does not.
  assign w_signedOvf = (acc[A-1] == addend[A-1]) && (w_raw[A-1] != acc[A-1]);

  // Clamp direction in signed mode follows the operand sign, since an
  // overflow can only happen when both operands share it.
  always_comb begin
    sum = w_raw[A-1:0];
    ovf = 1'b0;
    if (mode) begin
      if (w_signedOvf) begin
        ovf = 1'b1;
        sum = acc[A-1] ? S_MIN : S_MAX;
      end
    end else begin
      if (w_carry) begin
        ovf = 1'b1;
        sum = U_MAX;
      end
    end
  end

endmodule

// File: rtl/mult_acc_stage.sv
// ---------------------------------------------------------------------------
// mult_acc_stage
// Accumulates multiplier products over a frame and presents the saturated
// sum, beat count and sticky saturation flag once the last beat arrives.
// Ports:
//   clk        in  1   clock, all state on rising edge
//   rst_n      in  1   synchronous active-low reset
//   in_valid   in  1   product beat valid
//   in_ready   out 1   stage can accept a beat (low in HOLD and in reset)
//   in_product in  P   product (two's complement when in_signed)
//   in_signed  in  1   signed/unsigned product, latched on a frame's first beat
//   in_last    in  1   beat closes the frame
//   out_valid  out 1   result valid
//   out_ready  in  1   downstream accepts result
//   out_acc    out A   accumulated, saturated sum
//   out_sat    out 1   saturation happened somewhere in the frame
//   out_count  out 16  beats in the frame, saturating at 0xFFFF
// ---------------------------------------------------------------------------
module mult_acc_stage
  import mult_pkg::*;
#(
  parameter  int WL1   = 8,
  parameter  int WL2   = 8,
  parameter  int GUARD = 8,
  localparam int P     = prodWidth(WL1, WL2),
  localparam int A     = accWidth(WL1, WL2, GUARD)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [P-1:0]       in_product,
  input  logic               in_signed,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [A-1:0]       out_acc,
  output logic               out_sat,
  output logic [COUNT_W-1:0] out_count
);

  state_e               r_state;
  state_e               w_nextState;

  logic [A-1:0]         r_acc;
  logic [A-1:0]         w_nextAcc;
  logic [A-1:0]         w_addend;
  logic [A-1:0]         w_satSum;
  logic                 w_satOvf;

  logic                 r_mode;
  logic                 w_extMode;
  logic                 r_sat;
  logic                 w_nextSat;
  logic [COUNT_W-1:0]   r_count;
  logic [COUNT_W-1:0]   w_nextCount;

  logic                 w_accept;
  logic                 w_loadOut;

  logic [A-1:0]         r_outAcc;
  logic                 r_outSat;
  logic [COUNT_W-1:0]   r_outCount;
  logic                 r_outValid;

  // Readiness comes from the state register only, so out_ready never
  // reaches in_ready combinationally.
  assign in_ready = rst_n && (r_state != HOLD);
  assign w_accept = in_valid && in_ready;

  // The first beat of a frame is extended with its own in_signed value;
  // later beats use the mode latched from that first beat.
  assign w_extMode = (r_state == IDLE) ? in_signed : r_mode;
  assign w_addend  = w_extMode ? {{GUARD{in_product[P-1]}}, in_product}
                               : {{GUARD{1'b0}}, in_product};

  mult_acc_satadd #(
    .A(A)
  ) u_satadd (
    .acc   (r_acc),
    .addend(w_addend),
    .mode  (r_mode),
    .sum   (w_satSum),
    .ovf   (w_satOvf)
  );

  // Next-state and next-accumulator logic. A first beat replaces the
  // accumulator outright; subsequent beats go through the saturating adder.
  always_comb begin
    w_nextState = r_state;
    w_nextAcc   = r_acc;
    w_nextCount = r_count;
    w_nextSat   = r_sat;
    w_loadOut   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_nextAcc   = w_addend;
          w_nextCount = 16'd1;
          w_nextSat   = 1'b0;
          w_loadOut   = in_last;
          w_nextState = in_last ? HOLD : ACC;
        end
      end
      ACC: begin
        if (w_accept) begin
          w_nextAcc   = w_satSum;
          w_nextCount = (r_count == COUNT_MAX) ? r_count : r_count + 16'd1;
          w_nextSat   = r_sat | w_satOvf;
          w_loadOut   = in_last;
          w_nextState = in_last ? HOLD : ACC;
        end
      end
      HOLD: begin
        if (out_ready) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // State register; reset abandons any open frame or held result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Running accumulator, beat counter, sticky flag and latched mode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_count <= '0;
      r_sat   <= 1'b0;
      r_mode  <= 1'b0;
    end else begin
      r_acc   <= w_nextAcc;
      r_count <= w_nextCount;
      r_sat   <= w_nextSat;
      if ((r_state == IDLE) && w_accept) begin
        r_mode <= in_signed;
      end
    end
  end

  // Result registers load with the last beat's updated values so the
  // result appears one edge after that beat and stays put while held.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_outAcc   <= '0;
      r_outSat   <= 1'b0;
      r_outCount <= '0;
      r_outValid <= 1'b0;
    end else if (w_loadOut) begin
      r_outAcc   <= w_nextAcc;
      r_outSat   <= w_nextSat;
      r_outCount <= w_nextCount;
      r_outValid <= 1'b1;
    end else if (r_outValid && out_ready) begin
      r_outValid <= 1'b0;
    end
  end

  assign out_acc   = r_outAcc;
  assign out_sat   = r_outSat;
  assign out_count = r_outCount;
  assign out_valid = r_outValid;

endmodule
